// File: rtl/cnn_window_sequencer_pkg.sv
// Shared constants, FSM state encoding and the row-slice helper for the
// CNN window sequencer.
package cnn_seq_pkg;

  localparam int IMG_W    = 28;
  localparam int K        = 5;
  localparam int WIN_LAST = 23;
  localparam int PIX_W    = 8;
  localparam int ROW_BITS = 224;
  localparam int WIN_BITS = 200;
  localparam int SLICE_W  = K * PIX_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_FILL,
    S_WIN,
    S_SHIFT,
    S_WAIT_DONE,
    S_RESULT
  } state_t;

  // Five pixels starting at column x; pixel x ends up in the MSBs.
  function automatic logic [SLICE_W-1:0] row_slice(input logic [ROW_BITS-1:0] row,
                                                   input logic [4:0] x);
    logic [ROW_BITS-1:0] t;
    t = row >> (PIX_W * (WIN_LAST - int'(x)));
    return t[SLICE_W-1:0];
  endfunction

endpackage

// File: rtl/cnn_window_sequencer_if.sv
// Host, image-memory and CNN signals of the window sequencer.
// master = sequencer side, slave = environment (host/memory/CNN) side.
interface cnn_window_sequencer_if;
  import cnn_seq_pkg::*;

  logic                REQ;
  logic                BUSY;
  logic                MEM_REN;
  logic [4:0]          MEM_RADDR;
  logic [ROW_BITS-1:0] MEM_RDATA;
  logic                CNN_START;
  logic                CNN_WVALID;
  logic [4:0]          CNN_X;
  logic [4:0]          CNN_Y;
  logic [WIN_BITS-1:0] CNN_IMGIN;
  logic                CNN_DONE;
  logic [3:0]          CNN_OUT;
  logic                RES_VALID;
  logic [3:0]          RES_CLASS;
  logic                RES_ERR;

  modport master (
    input  REQ, MEM_RDATA, CNN_DONE, CNN_OUT,
    output BUSY, MEM_REN, MEM_RADDR, CNN_START, CNN_WVALID, CNN_X, CNN_Y,
           CNN_IMGIN, RES_VALID, RES_CLASS, RES_ERR
  );

  modport slave (
    output REQ, MEM_RDATA, CNN_DONE, CNN_OUT,
    input  BUSY, MEM_REN, MEM_RADDR, CNN_START, CNN_WVALID, CNN_X, CNN_Y,
           CNN_IMGIN, RES_VALID, RES_CLASS, RES_ERR
  );
endinterface

// File: rtl/cnn_window_sequencer_row_buffer.sv
// Five-row sliding image buffer. New rows enter at the bottom and every
// row moves up one place; the 5x5 window at column x is sliced out
// combinationally, top row in the MSBs.
module cnn_row_buffer
  import cnn_seq_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                shift_en,
  input  logic [ROW_BITS-1:0] row_in,
  input  logic [4:0]          x,
  output logic [WIN_BITS-1:0] win
);

  // rows[0] is window row Y, rows[K-1] is row Y+4
  logic [K-1:0][ROW_BITS-1:0] rows;

  // shift up and insert the returning memory row at the bottom
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rows <= '0;
    end else if (shift_en) begin
      for (int r = 0; r < K-1; r++) rows[r] <= rows[r+1];
      rows[K-1] <= row_in;
    end
  end

  for (genvar r = 0; r < K; r++) begin : g_row
    assign win[WIN_BITS-1-r*SLICE_W -: SLICE_W] = row_slice(rows[r], x);
  end

endmodule

// File: rtl/cnn_window_sequencer.sv
// Sequences one simpleCNN inference per host request: streams image rows
// into the sliding buffer, presents every 5x5 window (X outer, Y inner),
// then returns the class reported on CNN_DONE.
// Optional: define CNN_SEQ_TIMEOUT_EN to add a CNN_DONE watchdog.
module cnn_window_sequencer
  import cnn_seq_pkg::*;
#(
  parameter int HOLD_CYCLES    = 3,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic                    CLK,
  input logic                    nRST,
  cnn_window_sequencer_if.master bus
);

  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("HOLD_CYCLES must be at least 1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  // phase counter shared by FILL (6), WIN (HOLD_CYCLES) and SHIFT (2)
  localparam int CW = $clog2(HOLD_CYCLES + 6);

  state_t              state, state_d;
  logic [CW-1:0]       cnt, cnt_d;
  logic [4:0]          x, x_d, y, y_d;
  logic [4:0]          raddr_d;
  logic                ren_d, ren_dly;
  logic                done_q, done_edge;
  logic [3:0]          class_d;
  logic [WIN_BITS-1:0] win;

`ifdef CNN_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;
  logic          err_d;
`endif

  assign done_edge     = bus.CNN_DONE & ~done_q;
  assign bus.CNN_X     = x;
  assign bus.CNN_Y     = y;
  assign bus.CNN_IMGIN = win;

  // a row read issued last cycle returns now and shifts into the buffer
  cnn_row_buffer u_buf (
    .clk      (CLK),
    .rst_n    (nRST),
    .shift_en (ren_dly),
    .row_in   (bus.MEM_RDATA),
    .x        (x),
    .win      (win)
  );

  // next state, window position and next-cycle memory read
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    x_d     = x;
    y_d     = y;
    ren_d   = 1'b0;
    raddr_d = bus.MEM_RADDR;
    class_d = bus.RES_CLASS;
`ifdef CNN_SEQ_TIMEOUT_EN
    err_d   = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (bus.REQ) begin
          x_d     = '0;
          y_d     = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        state_d = S_FILL;
        cnt_d   = '0;
        ren_d   = 1'b1;
        raddr_d = '0;
      end
      S_FILL: begin
        // rows 0..4 issued on the first five cycles, sixth cycle drains
        if (cnt == CW'(5)) begin
          state_d = S_WIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CW'(1);
          if (cnt < CW'(K-1)) begin
            ren_d   = 1'b1;
            raddr_d = bus.MEM_RADDR + 5'd1;
          end
        end
      end
      S_WIN: begin
        if (cnt == CW'(HOLD_CYCLES-1)) begin
          cnt_d = '0;
          if (y < 5'(WIN_LAST)) begin
            state_d = S_SHIFT;
            ren_d   = 1'b1;
            raddr_d = y + 5'(K);
          end else if (x < 5'(WIN_LAST)) begin
            // next column restarts from the top of the image
            x_d     = x + 5'd1;
            y_d     = '0;
            state_d = S_FILL;
            ren_d   = 1'b1;
            raddr_d = '0;
          end else begin
            state_d = S_WAIT_DONE;
          end
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      S_SHIFT: begin
        if (cnt == CW'(1)) begin
          cnt_d   = '0;
          y_d     = y + 5'd1;
          state_d = S_WIN;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      S_WAIT_DONE: begin
        if (done_edge) begin
          class_d = bus.CNN_OUT;
          state_d = S_RESULT;
        end
`ifdef CNN_SEQ_TIMEOUT_EN
        else if (to_cnt == TW'(TIMEOUT_CYCLES-1)) begin
          class_d = 4'hF;
          err_d   = 1'b1;
          state_d = S_RESULT;
        end
`endif
      end
      S_RESULT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // state and registered outputs, decoded from the next state
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state          <= S_IDLE;
      cnt            <= '0;
      x              <= '0;
      y              <= '0;
      ren_dly        <= 1'b0;
      done_q         <= 1'b0;
      bus.MEM_REN    <= 1'b0;
      bus.MEM_RADDR  <= '0;
      bus.CNN_START  <= 1'b0;
      bus.BUSY       <= 1'b0;
      bus.CNN_WVALID <= 1'b0;
      bus.RES_VALID  <= 1'b0;
      bus.RES_CLASS  <= '0;
    end else begin
      state          <= state_d;
      cnt            <= cnt_d;
      x              <= x_d;
      y              <= y_d;
      ren_dly        <= bus.MEM_REN;
      done_q         <= bus.CNN_DONE;
      bus.MEM_REN    <= ren_d;
      bus.MEM_RADDR  <= raddr_d;
      bus.CNN_START  <= (state_d == S_START);
      bus.BUSY       <= (state_d != S_IDLE);
      bus.CNN_WVALID <= (state_d == S_WIN);
      bus.RES_VALID  <= (state_d == S_RESULT);
      bus.RES_CLASS  <= class_d;
    end
  end

`ifdef CNN_SEQ_TIMEOUT_EN
  // watchdog counts cycles spent in WAIT_DONE, cleared everywhere else
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      to_cnt      <= '0;
      bus.RES_ERR <= 1'b0;
    end else begin
      to_cnt      <= (state == S_WAIT_DONE) ? to_cnt + TW'(1) : '0;
      bus.RES_ERR <= err_d;
    end
  end
`else
  assign bus.RES_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_cnn_window_sequencer.sv
// Directed bench for cnn_window_sequencer: image memory model driving
// pixel(r,c) = (r*28+c) & 0xFF, hand-timed CNN_DONE stimulus.
module tb_cnn_window_sequencer;
  import cnn_seq_pkg::*;

  localparam int HOLD       = 3;
  localparam int TO_CYC     = 16;
  localparam int COL_CYC    = 6 + 24*HOLD + 23*2;
  localparam int WAIT_ENTRY = 2 + 24*COL_CYC;   // 2978

  logic CLK = 1'b0;
  logic nRST;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   raddr_hi = 0;

  cnn_window_sequencer_if bus ();

  cnn_window_sequencer #(.HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] pix(input int r, input int c);
    return 8'((r*28 + c) & 255);
  endfunction

  function automatic logic [ROW_BITS-1:0] row_img(input logic [4:0] r);
    logic [ROW_BITS-1:0] v;
    v = '0;
    for (int c = 0; c < 28; c++) v[223-8*c -: 8] = pix(int'(r), c);
    return v;
  endfunction

  function automatic logic [WIN_BITS-1:0] win_exp(input int x, input int y);
    logic [WIN_BITS-1:0] w;
    w = '0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        w[199-40*r-8*c -: 8] = pix(y+r, x+c);
    return w;
  endfunction

  // image memory: one-cycle read latency
  always @(posedge CLK) begin
    if (bus.MEM_REN) begin
      bus.MEM_RDATA <= row_img(bus.MEM_RADDR);
      if (bus.MEM_RADDR > 5'd27) raddr_hi <= raddr_hi + 1;
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic start_req();
    bus.REQ = 1'b1;
    cyc = 0;
    step();
    bus.REQ = 1'b0;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    bus.REQ = 1'b0;
    bus.CNN_DONE = 1'b0;
    bus.CNN_OUT = 4'h0;
    step();
    checks++;
    if ({bus.BUSY, bus.MEM_REN, bus.CNN_START, bus.CNN_WVALID, bus.RES_VALID, bus.RES_ERR} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 000000",
               {bus.BUSY, bus.MEM_REN, bus.CNN_START, bus.CNN_WVALID, bus.RES_VALID, bus.RES_ERR});
    end
    checks++;
    if ({bus.RES_CLASS, bus.MEM_RADDR, bus.CNN_X, bus.CNN_Y} !== 19'b0) begin
      errors++;
      $display("FAIL reset_fields: class %h raddr %0d x %0d y %0d want all 0",
               bus.RES_CLASS, bus.MEM_RADDR, bus.CNN_X, bus.CNN_Y);
    end
    checks++;
    if (bus.CNN_IMGIN !== '0) begin
      errors++;
      $display("FAIL reset_imgin: got %h want 0", bus.CNN_IMGIN);
    end
    step();
    nRST = 1'b1;
    step();
  endtask

  task automatic test_full_run();
    int nwin = 0, run = 0, win_bad = 0, hold_bad = 0, start_bad = 0;
    int last_wv = -1, rv_cnt = 0, rv_cyc = -1, busy_after = -1;
    logic prev_wv = 1'b0;
    logic [7:0] last_lo = 8'hxx;
    logic [3:0] rv_class = 4'hx;
    logic rv_err = 1'bx;
    start_req();
    checks++;
    if ({bus.CNN_START, bus.BUSY} !== 2'b11) begin
      errors++;
      $display("FAIL start_cycle1: start/busy %b want 11", {bus.CNN_START, bus.BUSY});
    end
    while (cyc < WAIT_ENTRY + 13) begin
      step();
      // stimulus for the cycle just entered
      if (cyc == 4)   begin bus.CNN_DONE = 1'b1; bus.CNN_OUT = 4'h3; end
      if (cyc == 5)   bus.CNN_DONE = 1'b0;
      if (cyc == 100) bus.REQ = 1'b1;
      if (cyc == 101) bus.REQ = 1'b0;
      if (cyc == WAIT_ENTRY + 10) begin bus.CNN_DONE = 1'b1; bus.CNN_OUT = 4'h7; end
      // observation
      if (bus.CNN_START) start_bad++;
      if (cyc == 2) begin
        checks++;
        if ({bus.MEM_REN, bus.MEM_RADDR} !== {1'b1, 5'd0}) begin
          errors++;
          $display("FAIL first_read: ren %b raddr %0d want 1/0", bus.MEM_REN, bus.MEM_RADDR);
        end
      end
      if (cyc == 7) begin
        checks++;
        if (bus.CNN_WVALID !== 1'b0) begin
          errors++;
          $display("FAIL wvalid_cycle7: got %b want 0", bus.CNN_WVALID);
        end
      end
      if (cyc == 8) begin
        checks++;
        if (bus.CNN_WVALID !== 1'b1) begin
          errors++;
          $display("FAIL wvalid_cycle8: got %b want 1", bus.CNN_WVALID);
        end
        checks++;
        if (bus.CNN_IMGIN[199:192] !== 8'h00) begin
          errors++;
          $display("FAIL win0_msb: got %h want 00", bus.CNN_IMGIN[199:192]);
        end
        checks++;
        if (bus.CNN_IMGIN[7:0] !== 8'h74) begin
          errors++;
          $display("FAIL win0_lsb: got %h want 74", bus.CNN_IMGIN[7:0]);
        end
      end
      if (bus.CNN_WVALID && !prev_wv) begin
        if ({bus.CNN_X, bus.CNN_Y} !== {5'(nwin/24), 5'(nwin%24)} ||
            bus.CNN_IMGIN !== win_exp(nwin/24, nwin%24)) win_bad++;
        nwin++;
        run = 0;
      end
      if (bus.CNN_WVALID) begin
        run++;
        last_wv = cyc;
        if (bus.CNN_X == 5'd23 && bus.CNN_Y == 5'd23) last_lo = bus.CNN_IMGIN[7:0];
      end
      if (!bus.CNN_WVALID && prev_wv && run != HOLD) hold_bad++;
      prev_wv = bus.CNN_WVALID;
      if (bus.RES_VALID) begin
        rv_cnt++;
        rv_cyc = cyc;
        rv_class = bus.RES_CLASS;
        rv_err = bus.RES_ERR;
        checks++;
        if (bus.BUSY !== 1'b1) begin
          errors++;
          $display("FAIL busy_at_result: got %b want 1", bus.BUSY);
        end
      end
      if (cyc == WAIT_ENTRY + 12) busy_after = int'(bus.BUSY);
    end
    bus.CNN_DONE = 1'b0;
    checks++;
    if (nwin != 576) begin errors++; $display("FAIL window_count: got %0d want 576", nwin); end
    checks++;
    if (win_bad != 0) begin errors++; $display("FAIL window_order_content: %0d bad want 0", win_bad); end
    checks++;
    if (hold_bad != 0) begin errors++; $display("FAIL window_hold: %0d bad want 0", hold_bad); end
    checks++;
    if (last_wv != WAIT_ENTRY - 1) begin
      errors++;
      $display("FAIL last_window_cycle: got %0d want %0d", last_wv, WAIT_ENTRY - 1);
    end
    checks++;
    if (last_lo !== 8'h0F) begin errors++; $display("FAIL last_window_lsb: got %h want 0f", last_lo); end
    checks++;
    if (start_bad != 0) begin errors++; $display("FAIL extra_start: %0d pulses want 0", start_bad); end
    checks++;
    if (rv_cnt != 1 || rv_cyc != WAIT_ENTRY + 11) begin
      errors++;
      $display("FAIL res_valid_timing: count %0d cycle %0d want 1/%0d", rv_cnt, rv_cyc, WAIT_ENTRY + 11);
    end
    checks++;
    if ({rv_class, rv_err} !== {4'h7, 1'b0}) begin
      errors++;
      $display("FAIL res_class_err: class %h err %b want 7/0", rv_class, rv_err);
    end
    checks++;
    if (busy_after != 0) begin errors++; $display("FAIL busy_after_result: got %0d want 0", busy_after); end
    checks++;
    if (bus.RES_CLASS !== 4'h7) begin errors++; $display("FAIL res_class_hold: got %h want 7", bus.RES_CLASS); end
    checks++;
    if (raddr_hi != 0) begin errors++; $display("FAIL raddr_range: %0d reads above 27 want 0", raddr_hi); end
  endtask

  task automatic test_reset_mid_win();
    start_req();
    while (cyc < 9) step();
    checks++;
    if (bus.CNN_WVALID !== 1'b1) begin errors++; $display("FAIL midwin_pre: wvalid %b want 1", bus.CNN_WVALID); end
    nRST = 1'b0;
    step();
    checks++;
    if ({bus.BUSY, bus.MEM_REN, bus.CNN_WVALID, bus.RES_VALID, bus.CNN_START} !== 5'b0 ||
        bus.CNN_IMGIN !== '0 || bus.RES_CLASS !== 4'h0) begin
      errors++;
      $display("FAIL midwin_reset: flags %b imgin %h class %h want all 0",
               {bus.BUSY, bus.MEM_REN, bus.CNN_WVALID, bus.RES_VALID, bus.CNN_START},
               bus.CNN_IMGIN, bus.RES_CLASS);
    end
    step();
    nRST = 1'b1;
    step();
    checks++;
    if ({bus.BUSY, bus.MEM_REN} !== 2'b00) begin
      errors++;
      $display("FAIL midwin_idle: busy/ren %b want 00", {bus.BUSY, bus.MEM_REN});
    end
  endtask

  task automatic test_reset_fill5();
    start_req();
    while (cyc < 2 + 5*COL_CYC + 2) step();
    checks++;
    if ({bus.MEM_REN, bus.MEM_RADDR, bus.CNN_X} !== {1'b1, 5'd2, 5'd5}) begin
      errors++;
      $display("FAIL fill5_pre: ren %b raddr %0d x %0d want 1/2/5", bus.MEM_REN, bus.MEM_RADDR, bus.CNN_X);
    end
    nRST = 1'b0;
    step();
    checks++;
    if ({bus.BUSY, bus.MEM_REN, bus.CNN_X, bus.CNN_Y} !== 12'b0 || bus.CNN_IMGIN !== '0) begin
      errors++;
      $display("FAIL fill5_reset: busy %b ren %b x %0d y %0d imgin %h want all 0",
               bus.BUSY, bus.MEM_REN, bus.CNN_X, bus.CNN_Y, bus.CNN_IMGIN);
    end
    step();
    nRST = 1'b1;
    step();
    start_req();
    checks++;
    if (bus.CNN_START !== 1'b1) begin errors++; $display("FAIL restart_start: got %b want 1", bus.CNN_START); end
    step();
    checks++;
    if ({bus.MEM_REN, bus.MEM_RADDR, bus.CNN_X, bus.CNN_Y} !== {1'b1, 15'd0}) begin
      errors++;
      $display("FAIL restart_read: ren %b raddr %0d x %0d y %0d want 1/0/0/0",
               bus.MEM_REN, bus.MEM_RADDR, bus.CNN_X, bus.CNN_Y);
    end
    while (cyc < 8) step();
    checks++;
    if (bus.CNN_WVALID !== 1'b1 || bus.CNN_IMGIN !== win_exp(0, 0)) begin
      errors++;
      $display("FAIL restart_window: wvalid %b imgin %h want 1/%h", bus.CNN_WVALID, bus.CNN_IMGIN, win_exp(0, 0));
    end
    nRST = 1'b0;
    step();
    step();
    nRST = 1'b1;
    step();
  endtask

`ifdef CNN_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int rv_cyc = -1;
    logic [3:0] rv_class = 4'hx;
    logic rv_err = 1'bx;
    start_req();
    while (cyc < WAIT_ENTRY + TO_CYC + 3) begin
      step();
      if (bus.RES_VALID && rv_cyc < 0) begin
        rv_cyc = cyc;
        rv_class = bus.RES_CLASS;
        rv_err = bus.RES_ERR;
      end
    end
    checks++;
    if (rv_cyc != WAIT_ENTRY + TO_CYC) begin
      errors++;
      $display("FAIL timeout_cycle: got %0d want %0d", rv_cyc, WAIT_ENTRY + TO_CYC);
    end
    checks++;
    if ({rv_class, rv_err} !== {4'hF, 1'b1}) begin
      errors++;
      $display("FAIL timeout_result: class %h err %b want f/1", rv_class, rv_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_full_run();
    test_reset_mid_win();
    test_reset_fill5();
`ifdef CNN_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
